// File: rtl/fir_sample_feeder.sv
// Input sequencer for a time-multiplexed FIR. It buffers upstream samples in a
// FIFO whose head sits in fir_sig, and releases one sample per TAPS-cycle frame.
module fir_sample_feeder #(
  parameter int WIDTH      = 18,
  parameter int TAPS       = 128,
  parameter int FIFO_DEPTH = 8,
  localparam int TW = $clog2(TAPS),
  localparam int LW = $clog2(FIFO_DEPTH + 1),
  localparam int BD = FIFO_DEPTH - 1,
  localparam int BW = (BD > 1) ? $clog2(BD) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic             en,
  output logic [WIDTH-1:0] fir_sig,
  output logic             fir_ready,
  output logic             out_valid,
  output logic [LW-1:0]    level,
  output logic             overflow
);

  logic [TW-1:0]    tap_cnt;
  logic             head_valid, primed;
  logic [WIDTH-1:0] body [BD];
  logic [BW-1:0]    wr_ptr, rd_ptr;
  logic [LW-1:0]    body_cnt;
  logic             last_slot, load, push, refill, body_rd, bypass, body_wr;

  function automatic logic [BW-1:0] ptr_inc(input logic [BW-1:0] p);
    return (p == BW'(BD - 1)) ? '0 : p + 1'b1;
  endfunction

  assign last_slot = (tap_cnt == TW'(TAPS - 1));
  assign fir_ready = !last_slot || (head_valid && en);
  assign load      = last_slot && fir_ready;
  assign level     = body_cnt + LW'(head_valid);
  assign s_ready   = (level != LW'(FIFO_DEPTH));
  assign push      = s_valid && s_ready;

  // The head register refills whenever it is empty or being consumed; a push
  // into an otherwise empty FIFO goes straight to the head.
  assign refill  = !head_valid || load;
  assign body_rd = refill && (body_cnt != '0);
  assign bypass  = refill && (body_cnt == '0) && push;
  assign body_wr = push && !bypass;

  always_ff @(posedge clk) begin
    if (body_wr) body[wr_ptr] <= s_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fir_sig    <= '0;
      head_valid <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      body_cnt   <= '0;
    end else begin
      if (body_rd)     fir_sig <= body[rd_ptr];
      else if (bypass) fir_sig <= s_data;
      if (refill) head_valid <= body_rd || bypass;
      if (body_wr) wr_ptr <= ptr_inc(wr_ptr);
      if (body_rd) rd_ptr <= ptr_inc(rd_ptr);
      case ({body_wr, body_rd})
        2'b10:   body_cnt <= body_cnt + 1'b1;
        2'b01:   body_cnt <= body_cnt - 1'b1;
        default: body_cnt <= body_cnt;
      endcase
    end
  end

  // Slot counter starts at the load slot, matching the filter's all-ones index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tap_cnt   <= TW'(TAPS - 1);
      primed    <= 1'b0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (fir_ready) tap_cnt <= last_slot ? '0 : tap_cnt + 1'b1;
      primed    <= primed || load;
      out_valid <= load && primed;
      overflow  <= overflow || (s_valid && !s_ready);
    end
  end

endmodule

// File: tb/tb_fir_sample_feeder.sv
// Randomized bench for fir_sample_feeder against a queue-based frame model.
module tb_fir_sample_feeder;
  localparam int W = 18, T = 128, D = 8, LW = $clog2(D + 1);

  logic          clk = 0, rst_n = 1;
  logic [W-1:0]  s_data = '0;
  logic          s_valid = 0, en = 0;
  logic          s_ready, fir_ready, out_valid, overflow;
  logic [W-1:0]  fir_sig;
  logic [LW-1:0] level;

  fir_sample_feeder #(.WIDTH(W), .TAPS(T), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .en(en), .fir_sig(fir_sig), .fir_ready(fir_ready),
    .out_valid(out_valid), .level(level), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int passed = 0, total = 0;
  logic [W-1:0] q[$];
  int  cnt;
  bit  primed, ovf, ov_exp;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    q.delete(); cnt = T - 1; primed = 0; ovf = 0; ov_exp = 0;
  endtask

  function automatic bit exp_ready();
    return (cnt != T - 1) || (q.size() > 0 && en);
  endfunction

  task automatic check_outs();
    chk("fir_ready", fir_ready, exp_ready());
    chk("s_ready", s_ready, q.size() < D);
    chk("level", level, q.size());
    chk("out_valid", out_valid, ov_exp);
    chk("overflow", overflow, ovf);
    if (q.size() > 0) chk("fir_sig", fir_sig, q[0]);
  endtask

  // One cycle: drive at the falling edge, check, then advance model at the rising edge.
  task automatic cyc(input logic v, input logic [W-1:0] d, input logic e);
    bit fr, ld, ps, full;
    s_valid = v; s_data = d; en = e;
    #1;
    check_outs();
    fr   = exp_ready();
    ld   = (cnt == T - 1) && fr;
    full = (q.size() >= D);
    ps   = v && !full;
    @(posedge clk);
    if (ld) void'(q.pop_front());
    if (ps) q.push_back(d);
    ov_exp = ld && primed;
    primed = primed || ld;
    ovf    = ovf || (v && full);
    if (fr) cnt = (cnt + 1) % T;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 0; s_valid = 0;
    #1;
    model_reset();
    check_outs();
    chk("rst_fir_sig", fir_sig, 0);
    @(negedge clk);
    rst_n = 1;
  endtask

  function automatic logic [W-1:0] rnd();
    return W'($urandom());
  endfunction

  initial begin
    logic e;
    int rate;
    #2;
    do_reset();

    // single sample: one load, 127 accumulate slots, then stall with no out_valid
    cyc(1, 18'h00100, 1);
    repeat (140) cyc(0, '0, 1);

    // three back-to-back samples
    do_reset();
    repeat (3) cyc(1, rnd(), 1);
    repeat (400) cyc(0, '0, 1);

    // fill with en low, ninth push overflows and is dropped
    do_reset();
    repeat (9) cyc(1, rnd(), 0);
    chk("fill_level", level, D);
    chk("fill_ovf", overflow, 1);
    repeat (8 * T + 20) cyc(0, '0, 1);

    // en dropped mid-frame, then raised at the load slot
    do_reset();
    repeat (4) cyc(1, rnd(), 1);
    for (int i = 0; i < 300 && cnt != 40; i++) cyc(0, '0, 1);
    repeat (150) cyc(0, '0, 0);
    chk("endrop_stall", fir_ready, 0);
    repeat (10) cyc(0, '0, 1);

    // starvation: drain, stall for at least 500 cycles, then resume
    repeat (4 * T + 520) cyc(0, '0, 1);
    cyc(1, rnd(), 1);
    repeat (140) cyc(0, '0, 1);

    // randomized traffic with varying push rate and en toggling
    do_reset();
    e = 1;
    for (int b = 0; b < 8; b++) begin
      rate = $urandom_range(2, 300);
      repeat (500) begin
        if ($urandom_range(0, 149) == 0) e = ~e;
        cyc($urandom_range(0, rate - 1) == 0, rnd(), e);
      end
    end

    // asynchronous reset mid-frame with a partly full FIFO
    do_reset();
    for (int i = 0; i < 300 && !(cnt == 60 && q.size() == 5); i++)
      cyc(q.size() < 5, rnd(), 1);
    chk("pre_rst_level", level, 5);
    do_reset();
    repeat (5) cyc(0, '0, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
